// File: rtl/phy_init_pkg.sv
// Shared constants, state encoding and frame builder for the PHY link bring-up sequencer.
package phy_init_pkg;

    localparam logic [1:0] MDIO_ST            = 2'b01;
    localparam logic [1:0] MDIO_OP_WR         = 2'b01;
    localparam logic [1:0] MDIO_TA            = 2'b10;
    localparam int         MDIO_PREAMBLE_BITS = 32;
    localparam int         MDIO_FRAME_BITS    = 64;
    localparam int         REG_ENTRY_W        = 21;

    typedef enum logic [2:0] {
        IDLE,
        PCS_RST,
        WAIT_DONE,
        FRAME,
        GAP,
        DONE
    } state_t;

    // Clause-22 write frame, sent MSB first.
    function automatic logic [MDIO_FRAME_BITS-1:0] build_frame(
        input logic [4:0]             phyad,
        input logic [REG_ENTRY_W-1:0] entry
    );
        return {{MDIO_PREAMBLE_BITS{1'b1}}, MDIO_ST, MDIO_OP_WR, phyad,
                entry[20:16], MDIO_TA, entry[15:0]};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: divides CLK by 2*CLK_DIV and flags the cycle before each MDC edge.
module mdio_clk_gen #(
    parameter int CLK_DIV = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             mdc_q;
    logic             wrap;

    // Strobes are high in the cycle whose closing edge toggles MDC.
    assign wrap     = en && !clr && (div_q == DIV_LAST);
    assign mdc      = mdc_q;
    assign mdc_rise = wrap && !mdc_q;
    assign mdc_fall = wrap && mdc_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_q <= '0;
            mdc_q <= 1'b0;
        end else if (en) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                mdc_q <= ~mdc_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_link_init_seq.sv
// Resets the PCS/PMA core, waits for its resetdone edge, then writes a table of
// Clause-22 MDIO registers to the PHY.
module phy_link_init_seq
    import phy_init_pkg::*;
#(
    parameter int NUM_REGS      = 2,
    parameter int CLK_DIV       = 64,
    parameter int RST_PULSE_LEN = 4,
    parameter int SYNC_STAGES   = 3,
    parameter int GAP_BITS      = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [4:0]                        PHYAD,
    input  logic [NUM_REGS*REG_ENTRY_W-1:0]   REG_TABLE,
    input  logic                              RESETDONE,
    input  logic                              RESTART,
    output logic                              PCS_RESET,
    output logic                              MDC,
    output logic                              MDIO_OUT,
    output logic                              BUSY,
    output logic                              COMPLETE,
    output logic [$clog2(NUM_REGS+1)-1:0]     FRAME_CNT,
    output state_t                            STATE_DBG
);

    localparam int CNT_W = $clog2(NUM_REGS + 1);
    localparam int TMR_W = max_int(max_int($clog2(RST_PULSE_LEN + 1), $clog2(GAP_BITS + 1)),
                                   $clog2(MDIO_FRAME_BITS + 1));
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(RST_PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] BITS_ALL   = TMR_W'(MDIO_FRAME_BITS);
    localparam logic [TMR_W-1:0] GAP_ALL    = TMR_W'(GAP_BITS);

    state_t                     state_q, state_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d;
    logic [MDIO_FRAME_BITS-1:0] sr_q, sr_d;
    logic                       mdio_q, mdio_d;
    logic                       complete_q, complete_d;
    logic                       busy_q, busy_d;
    logic                       pcs_reset_q, pcs_reset_d;
    logic [CNT_W-1:0]           frame_cnt_q, frame_cnt_d;
    logic [SYNC_STAGES-1:0]     sync_q;
    logic                       done_prev_q;
    logic                       done_rise;
    logic                       clk_en, clk_clr;
    logic                       mdc_rise, mdc_fall;
    logic [REG_ENTRY_W-1:0]     entry_sel;
    logic [MDIO_FRAME_BITS-1:0] frame_w;

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (CLK),
        .rst      (RST),
        .en       (clk_en),
        .clr      (clk_clr),
        .mdc      (MDC),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    assign done_rise = sync_q[SYNC_STAGES-1] && !done_prev_q;

    // FRAME_CNT doubles as the table index of the next frame to send.
    always_comb begin
        entry_sel = REG_TABLE[REG_ENTRY_W-1:0];
        for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_cnt_q == CNT_W'(i)) entry_sel = REG_TABLE[i*REG_ENTRY_W +: REG_ENTRY_W];
        end
    end

    assign frame_w = build_frame(PHYAD, entry_sel);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            sr_q        <= '1;
            mdio_q      <= 1'b1;
            complete_q  <= 1'b0;
            busy_q      <= 1'b0;
            pcs_reset_q <= 1'b0;
            frame_cnt_q <= '0;
            sync_q      <= '0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            sr_q        <= sr_d;
            mdio_q      <= mdio_d;
            complete_q  <= complete_d;
            busy_q      <= busy_d;
            pcs_reset_q <= pcs_reset_d;
            frame_cnt_q <= frame_cnt_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], RESETDONE};
            done_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // tmr counts completed MDC periods on rises; state moves happen on the following fall.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        sr_d        = sr_q;
        mdio_d      = mdio_q;
        complete_d  = complete_q;
        frame_cnt_d = frame_cnt_q;
        clk_en      = 1'b0;
        clk_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                clk_clr = 1'b1;
                state_d = PCS_RST;
                tmr_d   = PULSE_LAST;
            end
            PCS_RST: begin
                clk_clr = 1'b1;
                if (tmr_q == '0) state_d = WAIT_DONE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            WAIT_DONE: begin
                clk_clr = 1'b1;
                if (done_rise) begin
                    state_d = FRAME;
                    tmr_d   = '0;
                    sr_d    = frame_w;
                    mdio_d  = frame_w[MDIO_FRAME_BITS-1];
                end
            end
            FRAME: begin
                clk_en = 1'b1;
                if (mdc_rise) tmr_d = tmr_q + 1'b1;
                if (mdc_fall) begin
                    if (tmr_q == BITS_ALL) begin
                        state_d     = GAP;
                        tmr_d       = '0;
                        mdio_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        sr_d   = {sr_q[MDIO_FRAME_BITS-2:0], 1'b1};
                        mdio_d = sr_q[MDIO_FRAME_BITS-2];
                    end
                end
            end
            GAP: begin
                clk_en = 1'b1;
                if (mdc_rise) tmr_d = tmr_q + 1'b1;
                if (mdc_fall && tmr_q == GAP_ALL) begin
                    tmr_d = '0;
                    if (frame_cnt_q == CNT_W'(NUM_REGS)) begin
                        state_d    = DONE;
                        complete_d = 1'b1;
                    end else begin
                        state_d = FRAME;
                        sr_d    = frame_w;
                        mdio_d  = frame_w[MDIO_FRAME_BITS-1];
                    end
                end
            end
            DONE: begin
                clk_clr = 1'b1;
                mdio_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (RESTART && state_q != IDLE) begin
            state_d     = PCS_RST;
            tmr_d       = PULSE_LAST;
            mdio_d      = 1'b1;
            complete_d  = 1'b0;
            frame_cnt_d = '0;
            clk_en      = 1'b0;
            clk_clr     = 1'b1;
        end

        busy_d      = state_d inside {PCS_RST, WAIT_DONE, FRAME, GAP};
        pcs_reset_d = (state_d == PCS_RST);
    end

    assign PCS_RESET = pcs_reset_q;
    assign MDIO_OUT  = mdio_q;
    assign BUSY      = busy_q;
    assign COMPLETE  = complete_q;
    assign FRAME_CNT = frame_cnt_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_phy_link_init_seq.sv
// Bench for phy_link_init_seq: randomized register tables checked against a bit-level MDIO model.
module tb_phy_link_init_seq;
    import phy_init_pkg::*;

    localparam int NUM_REGS      = 2;
    localparam int CLK_DIV       = 2;
    localparam int RST_PULSE_LEN = 4;
    localparam int SYNC_STAGES   = 3;
    localparam int GAP_BITS      = 4;
    localparam int CNT_W         = $clog2(NUM_REGS + 1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [4:0]              phyad;
    logic [NUM_REGS*21-1:0]  reg_table;
    logic                    resetdone;
    logic                    restart;
    logic                    pcs_reset;
    logic                    mdc;
    logic                    mdio_out;
    logic                    busy;
    logic                    complete;
    logic [CNT_W-1:0]        frame_cnt;
    state_t                  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q[$];

    phy_link_init_seq #(
        .NUM_REGS      (NUM_REGS),
        .CLK_DIV       (CLK_DIV),
        .RST_PULSE_LEN (RST_PULSE_LEN),
        .SYNC_STAGES   (SYNC_STAGES),
        .GAP_BITS      (GAP_BITS)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .PHYAD     (phyad),
        .REG_TABLE (reg_table),
        .RESETDONE (resetdone),
        .RESTART   (restart),
        .PCS_RESET (pcs_reset),
        .MDC       (mdc),
        .MDIO_OUT  (mdio_out),
        .BUSY      (busy),
        .COMPLETE  (complete),
        .FRAME_CNT (frame_cnt),
        .STATE_DBG (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: MDIO bits seen at MDC rises
    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    task automatic push_frame(input logic [4:0] ad, input logic [20:0] ent);
        push_bits(32'hFFFF_FFFF, 32);
        push_bits(32'b01, 2);
        push_bits(32'b01, 2);
        push_bits(32'(ad), 5);
        push_bits(32'(ent[20:16]), 5);
        push_bits(32'b10, 2);
        push_bits(32'(ent[15:0]), 16);
        push_bits(32'hFFFF_FFFF, GAP_BITS);
    endtask

    task automatic randomize_inputs();
        phyad = 5'($urandom_range(0, 31));
        for (int i = 0; i < NUM_REGS; i++) reg_table[i*21 +: 21] = 21'($urandom);
    endtask

    // driver tasks
    task automatic reset_checks(input string tag);
        check_val({tag, "_pcs_reset"}, pcs_reset, 0);
        check_val({tag, "_mdc"}, mdc, 0);
        check_val({tag, "_mdio"}, mdio_out, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_complete"}, complete, 0);
        check_val({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    task automatic measure_pulse(input string tag);
        int hi = 0;
        int busy_bad = 0;
        while (pcs_reset === 1'b1 && hi < 50) begin
            if (busy !== 1'b1) busy_bad++;
            hi++;
            tick();
        end
        check_val({tag, "_len"}, hi, RST_PULSE_LEN);
        check_val({tag, "_busy"}, busy_bad, 0);
    endtask

    task automatic release_and_pulse();
        rst = 1'b0;
        tick();
        check_val("pcs_rst_rise", pcs_reset, 1);
        measure_pulse("pcs_pulse");
    endtask

    task automatic wait_and_edge(input int delay);
        int bad = 0;
        int k = 0;
        repeat (delay) begin
            tick();
            if (mdc !== 1'b0 || busy !== 1'b1 || pcs_reset !== 1'b0) bad++;
        end
        check_val("wait_quiet", bad, 0);
        resetdone = 1'b1;
        do begin
            tick();
            k++;
        end while (mdc !== 1'b1 && k < 40);
        check_val("first_mdc_lat_ok", (k <= SYNC_STAGES + 3) ? 1 : 0, 1);
    endtask

    // scoreboard: mode 0 full run, 1 restart mid-frame, 2 reset in gap, 3 full run with mid-frame input changes
    task automatic stream(input int mode, input int stop_after);
        int cyc = 0;
        int t_cnt1 = -1;
        int t_cnt2 = -1;
        int unstable = 0;
        int busy_bad = 0;
        int idle_bad = 0;
        logic mdc_prev, mdio_prev;
        exp_q.delete();
        push_frame(phyad, reg_table[20:0]);
        if (mode != 3) for (int i = 1; i < NUM_REGS; i++) push_frame(phyad, reg_table[i*21 +: 21]);
        check_val("mdio_bit", mdio_out, exp_q.pop_front());
        mdc_prev  = mdc;
        mdio_prev = mdio_out;
        while (complete !== 1'b1 && cyc < 4000) begin
            tick();
            cyc++;
            if (mdc === 1'b1 && mdc_prev === 1'b0) begin
                if (exp_q.size() == 0) check_val("extra_rise", 1, 0);
                else check_val("mdio_bit", mdio_out, exp_q.pop_front());
            end
            if (mdio_out !== mdio_prev && !(mdc_prev === 1'b1 && mdc === 1'b0)) unstable++;
            if (busy !== 1'b1 && complete !== 1'b1) busy_bad++;
            if (frame_cnt == 1 && t_cnt1 < 0) t_cnt1 = cyc;
            if (frame_cnt == 2 && t_cnt2 < 0) t_cnt2 = cyc;
            mdc_prev  = mdc;
            mdio_prev = mdio_out;
            if (mode == 3 && cyc == 40) begin
                randomize_inputs();
                for (int i = 1; i < NUM_REGS; i++) push_frame(phyad, reg_table[i*21 +: 21]);
            end
            if (mode == 1 && cyc == stop_after) begin
                restart   = 1'b1;
                resetdone = 1'b0;
                tick();
                restart = 1'b0;
                check_val("restart_mdc", mdc, 0);
                check_val("restart_mdio", mdio_out, 1);
                check_val("restart_pcs_reset", pcs_reset, 1);
                check_val("restart_frame_cnt", frame_cnt, 0);
                check_val("restart_complete", complete, 0);
                return;
            end
            if (mode == 2 && t_cnt1 >= 0 && cyc == t_cnt1 + 3) begin
                check_val("gap_frame_cnt", frame_cnt, 1);
                rst       = 1'b1;
                resetdone = 1'b0;
                tick();
                reset_checks("rst_in_gap");
                return;
            end
        end
        check_val("complete", complete, 1);
        check_val("done_frame_cnt", frame_cnt, NUM_REGS);
        check_val("done_mdc", mdc, 0);
        check_val("done_mdio", mdio_out, 1);
        check_val("done_busy", busy, 0);
        check_val("bits_left", exp_q.size(), 0);
        check_val("mdio_stable", unstable, 0);
        check_val("busy_during_run", busy_bad, 0);
        check_val("frame0_len", t_cnt1, 128 * CLK_DIV - CLK_DIV);
        check_val("frame1_spacing", t_cnt2 - t_cnt1, (128 + 2 * GAP_BITS) * CLK_DIV);
        repeat (30) begin
            tick();
            if (mdc !== 1'b0 || complete !== 1'b1 || busy !== 1'b0 || mdio_out !== 1'b1) idle_bad++;
        end
        check_val("done_terminal", idle_bad, 0);
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        restart   = 1'b0;
        resetdone = 1'b0;
        phyad     = '0;
        reg_table = '0;
        repeat (5) tick();
        reset_checks("reset");

        // fixed table: PHYAD 1, {00,1140} then {04,0021}
        phyad     = 5'h01;
        reg_table = {5'h04, 16'h0021, 5'h00, 16'h1140};
        release_and_pulse();
        wait_and_edge(20);
        stream(0, 0);

        // second fixed pair, sequence rerun via RESTART from DONE
        reg_table = {5'h00, 16'h1340, 5'h04, 16'h0021};
        restart   = 1'b1;
        resetdone = 1'b0;
        tick();
        restart = 1'b0;
        check_val("restart_done_complete", complete, 0);
        check_val("restart_done_frame_cnt", frame_cnt, 0);
        measure_pulse("restart_done_pulse");
        wait_and_edge($urandom_range(3, 30));
        stream(0, 0);

        // random table, inputs change mid-frame
        randomize_inputs();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        resetdone = 1'b0;
        measure_pulse("rand_pulse");
        wait_and_edge($urandom_range(3, 30));
        stream(3, 0);

        // RESTART mid-frame 0, then RESTART held high
        randomize_inputs();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        resetdone = 1'b0;
        measure_pulse("pre_abort_pulse");
        wait_and_edge($urandom_range(3, 30));
        stream(1, $urandom_range(10, 200));
        measure_pulse("abort_pulse");
        bad = 0;
        restart = 1'b1;
        repeat (10) begin
            tick();
            if (pcs_reset !== 1'b1) bad++;
        end
        restart = 1'b0;
        check_val("restart_hold_high", bad, 0);
        measure_pulse("restart_hold_release");
        wait_and_edge($urandom_range(3, 30));
        stream(0, 0);

        // RST during GAP, then full rerun from IDLE
        randomize_inputs();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        resetdone = 1'b0;
        measure_pulse("pre_gap_pulse");
        wait_and_edge($urandom_range(3, 30));
        stream(2, 0);
        release_and_pulse();
        wait_and_edge($urandom_range(3, 30));
        stream(0, 0);

        // RESETDONE already high at release: no edge, no progress
        rst       = 1'b1;
        resetdone = 1'b1;
        repeat (5) tick();
        reset_checks("held_reset");
        release_and_pulse();
        bad = 0;
        repeat (10000) begin
            tick();
            if (busy !== 1'b1 || mdc !== 1'b0 || mdio_out !== 1'b1) bad++;
        end
        check_val("held_high_stuck", bad, 0);
        check_val("held_high_state", state_dbg, WAIT_DONE);
        check_val("held_high_frame_cnt", frame_cnt, 0);
        resetdone = 1'b0;
        repeat (6) tick();
        randomize_inputs();
        wait_and_edge(4);
        stream(3, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/phy_link_init_seq.md
Name: phy_link_init_seq

Overview:
- Parametrised successor to the fixed SFP reset-delay logic plus single-purpose MII initializer in the SiTCP network wrapper.
- Issues a timed reset pulse to the PCS/PMA core and waits for its synchronised resetdone rising edge.
- Then writes a configurable table of Clause-22 MDIO registers to the PHY and reports completion.
- Sits between the PCS/PMA core (reset, mdc, mdio_i) and SiTCP-facing logic; any register set or PHY address needs no RTL change.

Parameters:
- NUM_REGS, 2, number of MDIO write frames in the table (legal range ≥1).
- CLK_DIV, 64, MDC half-period in CLK cycles (MDC = CLK/(2*CLK_DIV)); ≥2.
- RST_PULSE_LEN, 4, PCS_RESET high time in CLK cycles; ≥1.
- SYNC_STAGES, 3, synchroniser depth on RESETDONE; ≥2.
- GAP_BITS, 4, idle MDC periods (MDIO=1) after each frame; ≥1.

Ports:
- CLK  in  1  system clock (125 MHz rxuserclk2 domain).
- RST  in  1  reset; synchronous, active-high.
- PHYAD  in  5  PHY address; latched at each frame start.
- REG_TABLE  in  NUM_REGS*21  entry i = REG_TABLE[i*21 +: 21] = {regad[4:0], data[15:0]}; latched at frame start.
- RESETDONE  in  1  asynchronous resetdone from PCS/PMA.
- RESTART  in  1  single-cycle request to rerun the full sequence.
- PCS_RESET  out  1  reset pulse to PCS/PMA.
- MDC  out  1  management clock.
- MDIO_OUT  out  1  serial data to PCS/PMA mdio_i.
- BUSY  out  1  sequence in progress.
- COMPLETE  out  1  all frames written.
- FRAME_CNT  out  $clog2(NUM_REGS+1)  frames completed.

Behaviour:
- Reset values: PCS_RESET=0, MDC=0, MDIO_OUT=1, BUSY=0, COMPLETE=0, FRAME_CNT=0, divider=0, synchroniser flops=0, state=IDLE.
- RST asserted in any state: all outputs take their reset values on the next edge.

States:
- IDLE: lasts exactly 1 cycle after RST deasserts, then goes to PCS_RST.
- PCS_RST: PCS_RESET=1 for exactly RST_PULSE_LEN cycles, then goes to WAIT_DONE.
- WAIT_DONE: waits for a synchronised rising edge of RESETDONE (previous synced sample 0, current 1), then goes to FRAME with index 0.
  - A RESETDONE that stays high never advances the block; the edge is mandatory.
  - A rising edge arriving during PCS_RST is ignored.
- FRAME: loads a 64-bit shift register with {32 ones, 01 (ST), 01 (write OP), PHYAD, regad, 10 (TA), data}, shifted MSB-first.
  - Divider counts 0..CLK_DIV-1; MDC toggles on wrap.
  - MDIO_OUT updates only in the cycle where MDC falls (and at frame entry, with MDC=0), so each bit is stable for CLK_DIV cycles before and after every MDC rise.
  - Each bit is held 2*CLK_DIV cycles; frame length is 128*CLK_DIV cycles.
- GAP: MDIO_OUT=1 and MDC keeps toggling for GAP_BITS periods. FRAME_CNT increments on GAP entry.
  - Goes to FRAME with index+1 if index < NUM_REGS-1, otherwise to DONE.
- DONE: COMPLETE=1, BUSY=0, MDC=0, MDIO_OUT=1. Terminal until RESTART or RST.

Outputs and control:
- BUSY=1 in PCS_RST, WAIT_DONE, FRAME and GAP.
- RESTART in any non-IDLE state causes the following on the next edge:
  - state goes to PCS_RST with its pulse counter reloaded;
  - COMPLETE=0, FRAME_CNT=0, MDC=0, MDIO_OUT=1;
  - any frame in flight is aborted.
- RESTART held high re-enters PCS_RST every cycle, so PCS_RESET stays high.
- REG_TABLE or PHYAD changing mid-frame has no effect until the next frame start.

Decomposition:
- Package phy_init_pkg:
  - constants MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_TA=2'b10, MDIO_PREAMBLE_BITS=32, MDIO_FRAME_BITS=64, REG_ENTRY_W=21;
  - state encoding IDLE/PCS_RST/WAIT_DONE/FRAME/GAP/DONE.
- One sub-module, mdio_clk_gen: holds the divider and MDC register, and emits one-cycle mdc_rise / mdc_fall strobes. It has an enable and a synchronous clear.

Test Plan:
- CLK_DIV=2, RST_PULSE_LEN=4, NUM_REGS=2; release RST, raise RESETDONE 20 cycles after PCS_RESET falls -> PCS_RESET high cycles 2..5; first MDC rise ≤ SYNC_STAGES+3 cycles after the edge; BUSY=1 throughout.
- Same setup, PHYAD=5'h01, entry0={5'h00,16'h1140} -> bits sampled on MDC rises = 32 ones, 0101, 00001, 00000, 10, 0001000101000000; frame spans 256 cycles.
- Two entries {5'h04,16'h0021}, {5'h00,16'h1340} -> two frames separated by exactly 4 MDC periods with MDIO=1; then COMPLETE=1, FRAME_CNT=2, MDC=0.
- RESETDONE held high from before RST release -> block stays in WAIT_DONE (BUSY=1, no MDC activity) for 10000 cycles.
- RESTART pulsed mid-frame 0 -> next edge MDC=0, MDIO_OUT=1, PCS_RESET=1 for 4 cycles, FRAME_CNT=0; full sequence repeats after a new RESETDONE edge.
- RST asserted during GAP -> next edge all outputs at reset values; after release the sequence starts from IDLE.
